fetch_unit: RTL and testbench

//  Fetch stage of the brisc pipeline: owns the PC, issues instruction requests to the icache,
//  and holds the F/D pipeline register consumed by decode.

---
 rtl/brisc_pkg.sv | 25 ++
 rtl/fd_reg.sv | 65 ++++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : brisc_pkg                                              |
// | Description : Shared types and constants for the brisc pipeline.     |
// | Revision    : 1.0 - fetch stage types and constants                  |
// +----------------------------------------------------------------------+
package brisc_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_MISS = 2'd1,
        DISCARD   = 2'd2
    } fetch_state_e;

    typedef enum logic [0:0] {
        PC_PLUS4 = 1'b0,
        FROM_A   = 1'b1
    } pc_src_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/fd_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fd_reg                                                 |
// | Description : F/D pipeline register, priority flush > stall > load.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fd_reg
    import brisc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ILEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_stall,
    input  logic                  i_load,
    input  logic [ILEN-1:0]       i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [ILEN-1:0]       o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid
);

    localparam logic [ILEN-1:0]       c_nop     = ILEN'(NOP_INSTR);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);

    logic [ILEN-1:0]       r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;

    // Reset, flush and "nothing to load" all produce the same bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_instr    <= c_nop;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_stall) begin
            r_instr    <= r_instr;
            r_pc       <= r_pc;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + c_pc_step;
            r_valid    <= 1'b1;
        end else begin
            r_instr    <= c_nop;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit                                             |
// | Description : brisc fetch stage: PC, icache request, redirect        |
// |               tracking across misses, and the F/D register.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_unit
    import brisc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ILEN       = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(BOOT_ADDR_DEFAULT)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  stall_F_in,
    input  logic                  stall_D_in,
    input  logic                  flush_D_in,
    input  pc_src_e               pc_src_in,
    input  logic [ADDR_WIDTH-1:0] pc_target_A_in,
    input  logic                  icache_ready_in,
    input  logic [ILEN-1:0]       icache_instr_in,
    output logic                  icache_req_out,
    output logic [ADDR_WIDTH-1:0] icache_addr_out,
    output logic                  icache_mem_req_out,
    output logic [ILEN-1:0]       instr_D_out,
    output logic [ADDR_WIDTH-1:0] pc_D_out,
    output logic [ADDR_WIDTH-1:0] pc_plus4_D_out,
    output logic                  valid_D_out
);

    localparam logic [ADDR_WIDTH-1:0] c_pc_step    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  r_pend;
    logic                  w_pend_next;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] w_target_next;
    logic                  r_req;
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target_in;
    logic                  w_load;

    assign w_redirect  = (pc_src_in == FROM_A);
    assign w_target_in = pc_target_A_in & c_align_mask;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state  <= RUN;
            r_pc     <= BOOT_ADDR;
            r_pend   <= 1'b0;
            r_target <= '0;
            r_req    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_pend   <= w_pend_next;
            r_target <= w_target_next;
            r_req    <= 1'b1;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pend_next   = r_pend;
        w_target_next = r_target;
        w_load        = 1'b0;

        if (w_redirect) begin
            w_pend_next   = 1'b1;
            w_target_next = w_target_in;
        end

        case (r_state)
            RUN: begin
                w_load = icache_ready_in && !r_pend;
                if (!icache_ready_in) begin
                    w_state_next = WAIT_MISS;
                end else if (!stall_F_in) begin
                    if (w_redirect) begin
                        w_pc_next   = w_target_in;
                        w_pend_next = 1'b0;
                    end else if (r_pend) begin
                        w_pc_next   = r_target;
                        w_pend_next = 1'b0;
                    end else begin
                        w_pc_next = r_pc + c_pc_step;
                    end
                end
            end
            WAIT_MISS: begin
                // The fill-completion cycle acts as a RUN cycle unless a
                // redirect is known, in which case the word is wrong-path.
                if (icache_ready_in) begin
                    if (r_pend || w_redirect) begin
                        w_state_next = DISCARD;
                    end else begin
                        w_state_next = RUN;
                        w_load       = 1'b1;
                        if (!stall_F_in) begin
                            w_pc_next = r_pc + c_pc_step;
                        end
                    end
                end
            end
            DISCARD: begin
                w_pc_next    = w_redirect ? w_target_in : r_target;
                w_pend_next  = 1'b0;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign icache_req_out     = r_req;
    assign icache_addr_out    = r_pc;
    assign icache_mem_req_out = r_req & ~icache_ready_in;

    fd_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ILEN       (ILEN)
    ) u_fd_reg (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_flush    (flush_D_in),
        .i_stall    (stall_D_in),
        .i_load     (w_load),
        .i_instr    (icache_instr_in),
        .i_pc       (r_pc),
        .o_instr    (instr_D_out),
        .o_pc       (pc_D_out),
        .o_pc_plus4 (pc_plus4_D_out),
        .o_valid    (valid_D_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                          |
// | Description : Directed, table-driven bench for fetch_unit.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
    import brisc_pkg::*;

    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        stall_F_in;
    logic        stall_D_in;
    logic        flush_D_in;
    pc_src_e     pc_src_in;
    logic [31:0] pc_target_A_in;
    logic        icache_ready_in;
    logic [31:0] icache_instr_in;
    logic        icache_req_out;
    logic [31:0] icache_addr_out;
    logic        icache_mem_req_out;
    logic [31:0] instr_D_out;
    logic [31:0] pc_D_out;
    logic [31:0] pc_plus4_D_out;
    logic        valid_D_out;

    always #5 clk_in = ~clk_in;

    fetch_unit dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .stall_F_in         (stall_F_in),
        .stall_D_in         (stall_D_in),
        .flush_D_in         (flush_D_in),
        .pc_src_in          (pc_src_in),
        .pc_target_A_in     (pc_target_A_in),
        .icache_ready_in    (icache_ready_in),
        .icache_instr_in    (icache_instr_in),
        .icache_req_out     (icache_req_out),
        .icache_addr_out    (icache_addr_out),
        .icache_mem_req_out (icache_mem_req_out),
        .instr_D_out        (instr_D_out),
        .pc_D_out           (pc_D_out),
        .pc_plus4_D_out     (pc_plus4_D_out),
        .valid_D_out        (valid_D_out)
    );

    typedef struct {
        logic        rst_n;
        logic        stall_f;
        logic        stall_d;
        logic        flush_d;
        logic        redir;
        logic [31:0] target;
        logic        ready;
        logic [31:0] instr;
        logic        chk;
        logic [31:0] e_addr;
        logic        e_mem;
        logic [31:0] e_pcd;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic sf, input logic sd, input logic fd,
                         input logic redir, input logic [31:0] tgt, input logic rdy,
                         input logic [31:0] ins);
        rst_n_in        = rst_n;
        stall_F_in      = sf;
        stall_D_in      = sd;
        flush_D_in      = fd;
        pc_src_in       = redir ? FROM_A : PC_PLUS4;
        pc_target_A_in  = tgt;
        icache_ready_in = rdy;
        icache_instr_in = ins;
    endtask

    // rst_n sF sD fD redir target ready instr | chk addr mem pcD valid instrD
    task automatic v(input logic r, input logic sf, input logic sd, input logic fd,
                     input logic rd, input logic [31:0] t, input logic rdy, input logic [31:0] ins,
                     input logic c, input logic [31:0] ea, input logic em, input logic [31:0] ep,
                     input logic ev, input logic [31:0] ei);
        vecs.push_back('{r, sf, sd, fd, rd, t, rdy, ins, c, ea, em, ep, ev, ei});
    endtask

    initial begin
        // Reset, then hits
        v(0,0,0,0,0,0,          0,0,            0,32'h0,        0,32'h0,        0,N);
        v(0,0,0,0,0,0,          0,0,            1,32'h1000,     0,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_0001,1,32'h1000,     0,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_0002,1,32'h1004,     0,32'h1000,     1,32'hC0DE_0001);
        // Miss at 0x1008, ready low for 3 cycles
        v(1,0,0,0,0,0,          0,0,            1,32'h1008,     1,32'h1004,     1,32'hC0DE_0002);
        v(1,0,0,0,0,0,          0,0,            1,32'h1008,     1,32'h0,        0,N);
        v(1,0,0,0,0,0,          0,0,            1,32'h1008,     1,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_0003,1,32'h1008,     0,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_0004,1,32'h100C,     0,32'h1008,     1,32'hC0DE_0003);
        // Miss at 0x1010 with a redirect to 0x2002 arriving mid-miss
        v(1,0,0,0,0,0,          0,0,            1,32'h1010,     1,32'h100C,     1,32'hC0DE_0004);
        v(1,0,0,0,1,32'h2002,   0,0,            1,32'h1010,     1,32'h0,        0,N);
        v(1,0,0,0,0,0,          0,0,            1,32'h1010,     1,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hBAD0_0005,1,32'h1010,     0,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hBAD0_0006,1,32'h1010,     0,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_0007,1,32'h2000,     0,32'h0,        0,N);
        // stall_F and stall_D for two cycles
        v(1,1,1,0,0,0,          1,32'hC0DE_0008,1,32'h2004,     0,32'h2000,     1,32'hC0DE_0007);
        v(1,1,1,0,0,0,          1,32'hC0DE_0008,1,32'h2004,     0,32'h2000,     1,32'hC0DE_0007);
        v(1,0,0,0,0,0,          1,32'hC0DE_0008,1,32'h2004,     0,32'h2000,     1,32'hC0DE_0007);
        // Redirect to 0x3000 under stall_F
        v(1,1,0,0,1,32'h3000,   1,32'hC0DE_0009,1,32'h2008,     0,32'h2004,     1,32'hC0DE_0008);
        v(1,0,0,0,0,0,          1,32'hC0DE_000A,1,32'h2008,     0,32'h2008,     1,32'hC0DE_0009);
        v(1,0,0,0,0,0,          1,32'hC0DE_000B,1,32'h3000,     0,32'h0,        0,N);
        // flush_D together with stall_D: flush wins
        v(1,0,1,1,0,0,          1,32'hC0DE_000C,1,32'h3004,     0,32'h3000,     1,32'hC0DE_000B);
        // Reset in the middle of a miss
        v(1,0,0,0,0,0,          0,0,            1,32'h3008,     1,32'h0,        0,N);
        v(0,0,0,0,0,0,          0,0,            1,32'h3008,     1,32'h0,        0,N);
        v(1,0,0,0,0,0,          1,32'hC0DE_000D,1,32'h1000,     0,32'h0,        0,N);
        // Redirect to 0xFFFF_FFFE (aligned to ...FC), then wrap to 0
        v(1,0,0,0,1,32'hFFFF_FFFE,1,32'hC0DE_000E,1,32'h1004,   0,32'h1000,     1,32'hC0DE_000D);
        v(1,0,0,0,0,0,          1,32'hC0DE_000F,1,32'hFFFF_FFFC,0,32'h1004,     1,32'hC0DE_000E);
        v(1,0,0,0,0,0,          1,32'hC0DE_0010,1,32'h0,        0,32'hFFFF_FFFC,1,32'hC0DE_000F);
        v(1,0,0,0,0,0,          1,32'hC0DE_0011,1,32'h4,        0,32'h0,        1,32'hC0DE_0010);

        foreach (vecs[i]) begin
            @(negedge clk_in);
            drive(vecs[i].rst_n, vecs[i].stall_f, vecs[i].stall_d, vecs[i].flush_d,
                  vecs[i].redir, vecs[i].target, vecs[i].ready, vecs[i].instr);
            #1;
            if (vecs[i].chk) begin
                cmp($sformatf("row%0d addr", i),   icache_addr_out,    vecs[i].e_addr);
                cmp($sformatf("row%0d memreq", i), icache_mem_req_out, vecs[i].e_mem);
                cmp($sformatf("row%0d pcD", i),    pc_D_out,           vecs[i].e_pcd);
                cmp($sformatf("row%0d validD", i), valid_D_out,        vecs[i].e_valid);
                cmp($sformatf("row%0d instrD", i), instr_D_out,        vecs[i].e_instr);
                cmp($sformatf("row%0d pc4D", i),   pc_plus4_D_out,
                    vecs[i].e_valid ? vecs[i].e_pcd + 32'd4 : 32'h0);
            end
        end

        // Redirect arriving in the same cycle the fill completes (PC is 0x8 here)
        @(negedge clk_in);
        drive(1,0,0,0,0,0,0,0);
        #1;
        cmp("samecyc miss addr",   icache_addr_out,    32'h8);
        cmp("samecyc miss memreq", icache_mem_req_out, 32'h1);
        cmp("samecyc miss req",    icache_req_out,     32'h1);
        @(negedge clk_in);
        drive(1,0,0,0,1,32'h4000,1,32'hBAD0_0012);
        #1;
        cmp("samecyc fill memreq", icache_mem_req_out, 32'h0);
        @(negedge clk_in);
        drive(1,0,0,0,0,0,1,32'hBAD0_0013);
        #1;
        cmp("samecyc discard addr",  icache_addr_out, 32'h8);
        cmp("samecyc discard valid", valid_D_out,     32'h0);
        @(negedge clk_in);
        drive(1,0,0,0,0,0,1,32'hC0DE_0014);
        #1;
        cmp("samecyc target addr",  icache_addr_out, 32'h4000);
        cmp("samecyc target valid", valid_D_out,     32'h0);
        @(negedge clk_in);
        drive(1,0,0,0,0,0,1,32'hC0DE_0015);
        #1;
        cmp("samecyc load pcD",    pc_D_out,    32'h4000);
        cmp("samecyc load instrD", instr_D_out, 32'hC0DE_0014);
        cmp("samecyc load validD", valid_D_out, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
